// File: rtl/tpu_host_if.sv
// Host-side bundle between the TPU host driver and its environment: command,
// operand load stream, A/B/C global buffer ports, TPU control and result stream.
interface tpu_host_if;
    // Every valid/ready pair transfers one item on a rising clk edge where both
    // are high. The source holds its valid and payload stable until that edge,
    // and ready never depends combinationally on valid.
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_K;
    logic [7:0]   cmd_M;
    logic [7:0]   cmd_N;

    logic         ld_valid;
    logic         ld_ready;
    logic [31:0]  ld_data;

    logic         A_wr_en;
    logic [15:0]  A_index;
    logic [31:0]  A_data_in;
    logic         B_wr_en;
    logic [15:0]  B_index;
    logic [31:0]  B_data_in;
    logic [15:0]  C_index;
    logic [127:0] C_data_out;

    logic         tpu_in_valid;
    logic [7:0]   tpu_K;
    logic [7:0]   tpu_M;
    logic [7:0]   tpu_N;
    logic         tpu_busy;

    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_data;
    logic         res_last;
    logic         done;
    logic         err;

    modport master (
        input  cmd_valid, cmd_K, cmd_M, cmd_N,
        output cmd_ready,
        input  ld_valid, ld_data,
        output ld_ready,
        output A_wr_en, A_index, A_data_in,
        output B_wr_en, B_index, B_data_in,
        output C_index,
        input  C_data_out,
        output tpu_in_valid, tpu_K, tpu_M, tpu_N,
        input  tpu_busy,
        output res_valid, res_data, res_last,
        input  res_ready,
        output done, err
    );

    modport slave (
        output cmd_valid, cmd_K, cmd_M, cmd_N,
        input  cmd_ready,
        output ld_valid, ld_data,
        input  ld_ready,
        input  A_wr_en, A_index, A_data_in,
        input  B_wr_en, B_index, B_data_in,
        input  C_index,
        output C_data_out,
        input  tpu_in_valid, tpu_K, tpu_M, tpu_N,
        output tpu_busy,
        input  res_valid, res_data, res_last,
        output res_ready,
        input  done, err
    );
endinterface

// File: rtl/tpu_host_driver.sv
// Host initiator for the TPU core: loads A/B operands, starts the TPU, waits for
// completion (with guard window and timeout), then drains the C buffer as a stream.
module tpu_host_driver #(
    parameter int C_RD_LAT = 1,
    parameter int GUARD    = 2,
    parameter int TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    tpu_host_if.master  bus,
    output logic [6:0]  dbg_state_o
);

    // One-hot so every status output below is a single state flop.
    typedef enum logic [6:0] {
        IDLE      = 7'b0000001,
        LOAD_A    = 7'b0000010,
        LOAD_B    = 7'b0000100,
        START     = 7'b0001000,
        WAIT_DONE = 7'b0010000,
        DRAIN     = 7'b0100000,
        DONE      = 7'b1000000
    } state_t;

    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [15:0]   na_q;
    logic [15:0]   nb_q;
    logic [15:0]   nc_q;
    logic [7:0]    k_q;
    logic [7:0]    m_q;
    logic [7:0]    n_q;
    logic [7:0]    guard_q;
    logic [15:0]   tmo_q;
    logic [1:0]    lat_q;
    logic          res_valid_q;
    logic          res_last_q;
    logic [127:0]  res_data_q;
    logic          err_q;

    // ceil(d/4) widened first, so d=255 does not wrap.
    function automatic logic [15:0] quads(input logic [7:0] d);
        return ({8'd0, d} + 16'd3) >> 2;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            na_q        <= '0;
            nb_q        <= '0;
            nc_q        <= '0;
            k_q         <= '0;
            m_q         <= '0;
            n_q         <= '0;
            guard_q     <= '0;
            tmo_q       <= '0;
            lat_q       <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        k_q   <= bus.cmd_K;
                        m_q   <= bus.cmd_M;
                        n_q   <= bus.cmd_N;
                        na_q  <= quads(bus.cmd_M) * {8'd0, bus.cmd_K};
                        nb_q  <= quads(bus.cmd_N) * {8'd0, bus.cmd_K};
                        nc_q  <= {8'd0, bus.cmd_M} * quads(bus.cmd_N);
                        cnt_q <= '0;
                        if (bus.cmd_K == 8'd0 || bus.cmd_M == 8'd0 || bus.cmd_N == 8'd0) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= LOAD_A;
                        end
                    end
                end
                LOAD_A: begin
                    if (bus.ld_valid) begin
                        if (cnt_q == na_q - 16'd1) begin
                            cnt_q   <= '0;
                            state_q <= LOAD_B;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (bus.ld_valid) begin
                        if (cnt_q == nb_q - 16'd1) begin
                            cnt_q   <= '0;
                            state_q <= START;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                START: begin
                    guard_q <= 8'(GUARD);
                    tmo_q   <= '0;
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // The TPU may not have raised busy yet right after the start pulse.
                    if (guard_q == 8'd0 && !bus.tpu_busy) begin
                        cnt_q   <= '0;
                        lat_q   <= '0;
                        state_q <= DRAIN;
                    end else if (tmo_q == 16'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                        if (guard_q != 8'd0) begin
                            guard_q <= guard_q - 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    // One read in flight: address held on C_index until the word is consumed.
                    if (!res_valid_q) begin
                        if (lat_q == 2'(C_RD_LAT)) begin
                            res_data_q  <= bus.C_data_out;
                            res_valid_q <= 1'b1;
                            res_last_q  <= (cnt_q == nc_q - 16'd1);
                            lat_q       <= '0;
                        end else begin
                            lat_q <= lat_q + 2'd1;
                        end
                    end else if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        res_last_q  <= 1'b0;
                        cnt_q       <= cnt_q + 16'd1;
                        if (res_last_q) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready    = (state_q == IDLE);
    assign bus.ld_ready     = (state_q == LOAD_A) || (state_q == LOAD_B);

    assign bus.A_wr_en      = bus.ld_valid && (state_q == LOAD_A);
    assign bus.A_index      = bus.A_wr_en ? cnt_q : 16'd0;
    assign bus.A_data_in    = bus.A_wr_en ? bus.ld_data : 32'd0;
    assign bus.B_wr_en      = bus.ld_valid && (state_q == LOAD_B);
    assign bus.B_index      = bus.B_wr_en ? cnt_q : 16'd0;
    assign bus.B_data_in    = bus.B_wr_en ? bus.ld_data : 32'd0;
    assign bus.C_index      = (state_q == DRAIN) ? cnt_q : 16'd0;

    assign bus.tpu_in_valid = (state_q == START);
    assign bus.tpu_K        = k_q;
    assign bus.tpu_M        = m_q;
    assign bus.tpu_N        = n_q;

    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_last     = res_last_q;
    assign bus.done         = (state_q == DONE);
    assign bus.err          = err_q;

    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_tpu_host_driver.sv
// Directed bench for tpu_host_driver: vector table of full runs plus hand-written
// error, timeout, stall and mid-run reset sequences.
module tb_tpu_host_driver;

    localparam logic [6:0] ST_IDLE  = 7'b0000001;
    localparam logic [6:0] ST_DRAIN = 7'b0100000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] dbg_state;

    always #5 clk = ~clk;

    tpu_host_if bus();

    tpu_host_driver #(.C_RD_LAT(1), .GUARD(2), .TIMEOUT(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    typedef struct {
        logic [7:0] k;
        logic [7:0] m;
        logic [7:0] n;
        int         na;
        int         nb;
        int         nc;
        bit         stall;
    } vec_t;

    vec_t vecs[6];

    int n_cmp = 0;
    int n_bad = 0;

    logic [47:0]  exp_a_q[$];
    logic [47:0]  exp_b_q[$];
    logic [128:0] exp_q[$];

    int         n_start, n_done, n_awr, n_bwr, n_stall;
    bit         drain_seen;
    logic [7:0] cur_k, cur_m, cur_n;
    bit         hold_busy = 1'b0;
    int         busy_left = 0;
    bit         rr_mode = 1'b0;
    int         rr_ph = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] c_word(input logic [15:0] i);
        return {16'hC0DE, i, ~i, i ^ 16'h5A5A, 32'hA5A5_0000 | {16'h0, i}, {i, i}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // C buffer model, one cycle read latency
    initial begin
        logic [15:0] idx;
        bus.C_data_out = '0;
        forever begin
            @(negedge clk);
            idx = bus.C_index;
            @(posedge clk);
            #1;
            bus.C_data_out = c_word(idx);
        end
    end

    // TPU model: busy for a few cycles after each start pulse, or forever when held
    initial begin
        bus.tpu_busy = 1'b0;
        forever begin
            step();
            if (bus.tpu_in_valid) busy_left = 5;
            bus.tpu_busy = hold_busy || (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
    end

    // Result consumer: always ready, or the 1-0-0-1 pattern
    initial begin
        bit pat[4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        bus.res_ready = 1'b0;
        forever begin
            step();
            if (!rr_mode) begin
                bus.res_ready = 1'b1;
            end else begin
                bus.res_ready = pat[rr_ph % 4];
                rr_ph++;
            end
        end
    end

    // Monitor / scoreboard, sampled mid-cycle
    initial begin
        bit           prev_stall = 1'b0;
        logic [127:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.A_wr_en) begin
                    n_awr++;
                    if (exp_a_q.size() == 0) check("a_unexpected_write", {bus.A_index, bus.A_data_in}, 0);
                    else check("a_write", {bus.A_index, bus.A_data_in}, exp_a_q.pop_front());
                end
                if (bus.B_wr_en) begin
                    n_bwr++;
                    if (exp_b_q.size() == 0) check("b_unexpected_write", {bus.B_index, bus.B_data_in}, 0);
                    else check("b_write", {bus.B_index, bus.B_data_in}, exp_b_q.pop_front());
                end
                if (bus.tpu_in_valid) begin
                    n_start++;
                    check("tpu_dims", {bus.tpu_K, bus.tpu_M, bus.tpu_N}, {cur_k, cur_m, cur_n});
                end
                if (bus.done) n_done++;
                if (dbg_state == ST_DRAIN) drain_seen = 1'b1;
                if (prev_stall) begin
                    n_stall++;
                    check("res_hold", {bus.res_valid, bus.res_data}, {1'b1, prev_data});
                end
                if (bus.res_valid && bus.res_ready) begin
                    if (exp_q.size() == 0) check("res_unexpected", {bus.res_last, bus.res_data}, 0);
                    else check("res_word", {bus.res_last, bus.res_data}, exp_q.pop_front());
                end
                prev_stall = bus.res_valid && !bus.res_ready;
                prev_data  = bus.res_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic clear_stats();
        n_start = 0; n_done = 0; n_awr = 0; n_bwr = 0; n_stall = 0;
        drain_seen = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n);
        int t = 0;
        cur_k = k; cur_m = m; cur_n = n;
        bus.cmd_valid = 1'b1;
        bus.cmd_K = k; bus.cmd_M = m; bus.cmd_N = n;
        while (!bus.cmd_ready && t < 50) begin
            step();
            t++;
        end
        if (!bus.cmd_ready) check("cmd_ready_timeout", 0, 1);
        else step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_word(input bit is_a, input int idx, input logic [31:0] w);
        int t = 0;
        if (idx % 3 == 2) step();
        bus.ld_valid = 1'b1;
        bus.ld_data  = w;
        while (!bus.ld_ready && t < 50) begin
            step();
            t++;
        end
        if (!bus.ld_ready) begin
            check("ld_ready_timeout", 0, 1);
        end else begin
            if (is_a) exp_a_q.push_back({16'(idx), w});
            else      exp_b_q.push_back({16'(idx), w});
            step();
        end
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
    endtask

    task automatic load_words(input int na, input int nb);
        for (int i = 0; i < na; i++) send_word(1'b1, i, 32'h01020304 + 32'(i) * 32'h04040404);
        for (int i = 0; i < nb; i++) send_word(1'b0, i, 32'hB0B00000 + 32'(i));
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!bus.done && cycles < budget) begin
            step();
            cycles++;
        end
        if (!bus.done) check("done_timeout", 0, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        clear_stats();
        rr_mode = v.stall;
        rr_ph   = 0;
        send_cmd(v.k, v.m, v.n);
        check("err_cleared_on_accept", bus.err, 0);
        for (int i = 0; i < v.nc; i++) exp_q.push_back({(i == v.nc - 1), c_word(16'(i))});
        load_words(v.na, v.nb);
        wait_done(3000, cyc);
        check("err_after_run", bus.err, 0);
        check("tpu_dims_held", {bus.tpu_K, bus.tpu_M, bus.tpu_N}, {v.k, v.m, v.n});
        check("a_write_count", n_awr, v.na);
        check("b_write_count", n_bwr, v.nb);
        check("start_pulses", n_start, 1);
        check("res_remaining", exp_q.size(), 0);
        if (v.stall) check("stall_seen", (n_stall > 0), 1);
        step();
        check("done_one_cycle", {bus.done, bus.cmd_ready}, 2'b01);
        check("done_count", n_done, 1);
        rr_mode = 1'b0;
    endtask

    initial begin
        int cyc;
        int t;
        // k, m, n, NA, NB, NC, stall
        vecs[0] = '{8'd4,   8'd4,   8'd4, 4,   4,   4,   1'b0};
        vecs[1] = '{8'd3,   8'd5,   8'd6, 6,   6,   10,  1'b0};
        vecs[2] = '{8'd2,   8'd7,   8'd3, 4,   2,   7,   1'b1};
        vecs[3] = '{8'd1,   8'd1,   8'd1, 1,   1,   1,   1'b0};
        vecs[4] = '{8'd255, 8'd1,   8'd1, 255, 255, 1,   1'b0};
        vecs[5] = '{8'd1,   8'd255, 8'd1, 64,  1,   255, 1'b0};

        bus.cmd_valid = 1'b0; bus.cmd_K = '0; bus.cmd_M = '0; bus.cmd_N = '0;
        bus.ld_valid = 1'b0; bus.ld_data = '0;
        clear_stats();

        #2 rst = 1'b1;
        #2;
        check("reset_cmd_ready", bus.cmd_ready, 1);
        check("reset_outputs", {bus.ld_ready, bus.A_wr_en, bus.B_wr_en, bus.tpu_in_valid,
                                bus.res_valid, bus.res_last, bus.done, bus.err}, 0);
        check("reset_state", dbg_state, ST_IDLE);
        check("reset_indices", {bus.A_index, bus.B_index, bus.C_index, bus.tpu_K}, 0);
        repeat (3) step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Zero dimension: error, done pulse, nothing else happens
        clear_stats();
        send_cmd(8'd4, 8'd0, 8'd4);
        check("zero_dim_done_err", {bus.done, bus.err}, 2'b11);
        step();
        check("zero_dim_after", {bus.done, bus.cmd_ready, bus.err}, 3'b011);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'hDEAD_BEEF;
        repeat (2) step();
        bus.ld_valid = 1'b0;
        check("zero_dim_no_activity", {n_awr[7:0], n_bwr[7:0], n_start[7:0]}, 0);
        run_vec(vecs[3]);

        // Timeout: busy never falls
        clear_stats();
        hold_busy = 1'b1;
        send_cmd(8'd1, 8'd1, 8'd1);
        load_words(1, 1);
        t = 0;
        while (!bus.tpu_in_valid && t < 50) begin
            step();
            t++;
        end
        check("timeout_start_seen", bus.tpu_in_valid, 1);
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            step();
            cyc++;
        end
        check("timeout_cycles", cyc, 33);
        check("timeout_err", bus.err, 1);
        check("timeout_no_drain", drain_seen, 0);
        hold_busy = 1'b0;
        step();
        check("timeout_err_sticky", {bus.err, bus.cmd_ready}, 2'b11);
        repeat (3) step();

        // Reset during LOAD_B
        clear_stats();
        send_cmd(8'd2, 8'd4, 8'd4);
        send_word(1'b1, 0, 32'h11110000);
        send_word(1'b1, 1, 32'h11110001);
        send_word(1'b0, 0, 32'h22220000);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'h22220001;
        rst = 1'b1;
        #2;
        check("midrst_cmd_ready", bus.cmd_ready, 1);
        check("midrst_outputs", {bus.ld_ready, bus.A_wr_en, bus.B_wr_en, bus.tpu_in_valid,
                                 bus.res_valid, bus.done, bus.err}, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        check("midrst_writes", {n_awr[7:0], n_bwr[7:0]}, {8'd2, 8'd1});
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        step();
        rst = 1'b0;
        step();
        run_vec(vecs[3]);

        check("queues_empty", {exp_a_q.size(), exp_b_q.size(), exp_q.size()}, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
